spi_frame_decoder: RTL and testbench
====================================

// Module: spi_frame_decoder
// PURPOSE
//  Passive SPI-bus decoder. Sits downstream of the stimulus SPI master and taps its sclk/sdo/cs lines.
//  Rebuilds each cmd/addr/[dummy]/data frame into one parallel record, handed off over a valid/ready port.
//  The record feeds the scoreboard/logger, so the stimulus stream can be checked against the DUT's SPI slave.
//  All inputs are synchronous to clk_i (same clock domain as the master); no CDC synchronisers.
// PARAMETERS
//  READ_CMD    8'd11  command code that inserts the dummy phase
//  DUMMY_BITS  32     sclk rising edges skipped between addr and data for READ_CMD (range 1..63)
// PORTS
//  clk_i        in   1   FPGA clock
//  rst_ni       in   1   reset, synchronous, active-low
//  spi_sclk     in   1   SPI clock from master (idles low, mode 0)
//  spi_sdo      in   1   SPI data from master, MSB first
//  spi_cs       in   1   SPI chip select, active-low
//  frame_valid  out  1   record holds a complete frame
//  frame_ready  in   1   consumer accepts record
//  frame_cmd    out  8   decoded command
//  frame_addr   out  32  decoded address
//  frame_data   out  32  decoded data (DUMMY phase excluded)
//  frame_cnt    out  16  frames delivered since reset, wraps 16'hFFFF->0
//  abort_o      out  1   sticky: cs rose mid-frame
//  overflow_o   out  1   sticky: frame completed while frame_valid was high and frame_ready low
// BEHAVIOUR
//  - Reset (rst_ni low at a clk_i rising edge): state=IDLE, sclk_q=0, all outputs 0. Reset wins over all other events.
//  - Edge detect: sclk_q <= spi_sclk each cycle. rise = spi_sclk & ~sclk_q.
//  - Bits are sampled only on rise with spi_cs low. A bit shifts into the low end of a 32-bit shifter (MSB first).
//  - bitcnt (6b) is loaded with the phase length-1 and decremented on each rise. Phase ends on the rise where bitcnt==0.
//  - FSM:
//    - IDLE:  spi_cs low -> CMD, bitcnt=7. A rise in the same cycle as the cs fall is sampled as cmd bit7.
//    - CMD:   8 bits -> latch cmd -> ADDR, bitcnt=31.
//    - ADDR:  32 bits -> latch addr -> DUMMY (bitcnt=DUMMY_BITS-1) if cmd==READ_CMD, else DATA (bitcnt=31).
//    - DUMMY: consume DUMMY_BITS rises; sdo ignored -> DATA, bitcnt=31.
//    - DATA:  32 bits -> frame complete. Go to CMD (bitcnt=7) if spi_cs still low, else IDLE. Back-to-back frames
//      need no cs toggle.
//  - Frame complete, record free (frame_valid low, or frame_ready high this cycle):
//    - Next cycle: frame_cmd/addr/data load, frame_valid=1, frame_cnt+1.
//    - Latency = 1 clk after the rise carrying data bit0.
//  - Frame complete, record blocked: new frame dropped, record unchanged, overflow_o=1 (sticky), frame_cnt unchanged.
//  - Handshake: transfer when frame_valid & frame_ready. frame_valid then drops next cycle unless a new frame loads
//    that same cycle. Record fields are stable while frame_valid high and not accepted.
//  - spi_cs high in CMD/ADDR/DUMMY/DATA, at or after the first sampled bit: partial frame discarded, abort_o=1 (sticky),
//    -> IDLE. cs high in IDLE: no effect.
//  - cs rising the same cycle as the final data rise: the rise is ignored (cs high) and the frame counts as aborted.
//  - Rises while spi_cs high: ignored. The pending record is never affected by aborts.
//  - Unknown commands decode as non-read (no dummy phase).
// TESTING
//  1. Write frame: cmd=8'd2, addr=32'd100, data=32'd100 -> one cycle after the last rise:
//     frame_valid=1, cmd=2, addr=100, data=100, frame_cnt=1.
//  2. Read frame: cmd=8'd11, addr=100, 32 dummy bits of 1s, data=32'h0 -> data=0 (dummy ignored), frame_cnt=1.
//  3. Back-to-back: write then read with cs held low, frame_ready tied 1 -> two records in order, frame_cnt=2,
//     abort_o=0.
//  4. Backpressure: frame_ready=0, send two frames -> first record held (cmd=2), overflow_o=1, frame_cnt=1.
//     Then frame_ready=1 -> valid drops.
//  5. Abort: cs raised after 20 addr bits -> abort_o=1, no frame_valid. Next full frame decodes correctly.
//  6. Reset mid-DATA: rst_ni low 1 cycle after 10 data bits -> all outputs 0, state IDLE. A following frame decodes with
//     frame_cnt=1.

Source files
------------

// File: rtl/spi_frame_decoder.sv
// Passive SPI mode-0 tap: rebuilds cmd/addr/[dummy]/data frames into one record on a valid/ready port.
// Record appears 1 clk after the rise carrying data bit0; a frame completing while the record is blocked is dropped.
module spi_frame_decoder #(
  parameter logic [7:0] READ_CMD   = 8'd11,
  parameter int         DUMMY_BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sclk,
  input  logic        spi_sdo,
  input  logic        spi_cs,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [7:0]  frame_cmd,
  output logic [31:0] frame_addr,
  output logic [31:0] frame_data,
  output logic [15:0] frame_cnt,
  output logic        abort_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

  state_t      state;
  logic        sclk_q;
  logic [5:0]  bitcnt;
  logic [31:0] shifter;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;

  logic        rise;
  logic        sample;
  logic        done;
  logic        free;
  logic [31:0] shift_nxt;

  assign rise      = spi_sclk & ~sclk_q;
  assign sample    = rise & ~spi_cs;
  assign shift_nxt = {shifter[30:0], spi_sdo};
  assign done      = (state == DATA) && sample && (bitcnt == 6'd0);
  assign free      = ~frame_valid | frame_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      sclk_q      <= 1'b0;
      bitcnt      <= 6'd0;
      shifter     <= 32'd0;
      cmd_q       <= 8'd0;
      addr_q      <= 32'd0;
      frame_valid <= 1'b0;
      frame_cmd   <= 8'd0;
      frame_addr  <= 32'd0;
      frame_data  <= 32'd0;
      frame_cnt   <= 16'd0;
      abort_o     <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      sclk_q <= spi_sclk;

      // Output record: load on completion when free, otherwise drop and flag.
      if (done) begin
        if (free) begin
          frame_cmd   <= cmd_q;
          frame_addr  <= addr_q;
          frame_data  <= shift_nxt;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
        end else begin
          overflow_o  <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!spi_cs) begin
            state <= CMD;
            if (rise) begin
              shifter <= shift_nxt;
              bitcnt  <= 6'd6;
            end else begin
              bitcnt  <= 6'd7;
            end
          end
        end
        default: begin
          if (spi_cs) begin
            // CMD with a full count means no bit of a new frame was taken yet.
            state <= IDLE;
            if (!(state == CMD && bitcnt == 6'd7)) abort_o <= 1'b1;
          end else if (sample) begin
            if (state != DUMMY) shifter <= shift_nxt;
            bitcnt <= bitcnt - 6'd1;
            if (bitcnt == 6'd0) begin
              case (state)
                CMD: begin
                  cmd_q  <= shift_nxt[7:0];
                  state  <= ADDR;
                  bitcnt <= 6'd31;
                end
                ADDR: begin
                  addr_q <= shift_nxt;
                  if (cmd_q == READ_CMD) begin
                    state  <= DUMMY;
                    bitcnt <= 6'(DUMMY_BITS - 1);
                  end else begin
                    state  <= DATA;
                    bitcnt <= 6'd31;
                  end
                end
                DUMMY: begin
                  state  <= DATA;
                  bitcnt <= 6'd31;
                end
                DATA: begin
                  state  <= CMD;
                  bitcnt <= 6'd7;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: record-level model fed by the stimulus, per-cycle compare, plus literal spot checks.
module tb_spi_frame_decoder;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        sdo = 1'b0;
  logic        cs = 1'b1;
  logic        ready = 1'b0;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [31:0] frame_addr;
  logic [31:0] frame_data;
  logic [15:0] frame_cnt;
  logic        abort_o;
  logic        overflow_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit abort_flag = 1'b0;
  rec_t pend;
  rec_t done_q[$];

  // Model state
  logic        m_valid;
  rec_t        m_rec;
  logic [15:0] m_cnt;
  logic        m_abort;
  logic        m_ovf;
  rec_t        rec;

  always #5 clk = ~clk;

  spi_frame_decoder dut (
    .clk_i(clk), .rst_ni(rst_n), .spi_sclk(sclk), .spi_sdo(sdo), .spi_cs(cs),
    .frame_valid(frame_valid), .frame_ready(ready), .frame_cmd(frame_cmd),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_cnt(frame_cnt),
    .abort_o(abort_o), .overflow_o(overflow_o)
  );

  // Record-level model: the stimulus queues every frame it completes cleanly.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rec   <= '0;
      m_cnt   <= 16'd0;
      m_abort <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      if (done_q.size() > 0) begin
        rec = done_q.pop_front();
        if (!m_valid || ready) begin
          m_valid <= 1'b1;
          m_rec   <= rec;
          m_cnt   <= m_cnt + 16'd1;
        end else begin
          m_ovf <= 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
      m_abort <= abort_flag;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      checks++;
      if (frame_valid !== m_valid || frame_cmd !== m_rec.cmd || frame_addr !== m_rec.addr ||
          frame_data !== m_rec.data || frame_cnt !== m_cnt || abort_o !== m_abort || overflow_o !== m_ovf) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t act v=%b cmd=%h addr=%h data=%h cnt=%0d ab=%b ov=%b req v=%b cmd=%h addr=%h data=%h cnt=%0d ab=%b ov=%b",
                 $time, frame_valid, frame_cmd, frame_addr, frame_data, frame_cnt, abort_o, overflow_o,
                 m_valid, m_rec.cmd, m_rec.addr, m_rec.data, m_cnt, m_abort, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; sdo = 1'b0; ready = 1'b0;
    abort_flag = 1'b0; done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tx_bit(input logic b, input bit fall_cs, input bit push, input bit cs_up);
    @(negedge clk);
    sdo = b;
    repeat (2) @(negedge clk);
    if (fall_cs) cs = 1'b0;
    if (cs_up) begin cs = 1'b1; abort_flag = 1'b1; end
    sclk = 1'b1;
    if (push) done_q.push_back(pend);
    repeat (2) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input int ndummy, input bit same_edge, input bit hold_cs, input bit cut_last);
    pend = '{cmd: c, addr: a, data: d};
    if (!same_edge && cs) begin
      @(negedge clk);
      cs = 1'b0;
    end
    for (int i = 7; i >= 0; i--) tx_bit(c[i], same_edge && i == 7, 1'b0, 1'b0);
    for (int i = 31; i >= 0; i--) tx_bit(a[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ndummy; i++) tx_bit(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 0; i--) tx_bit(d[i], 1'b0, (i == 0) && !cut_last, (i == 0) && cut_last);
    if (!hold_cs && !cut_last) begin
      @(negedge clk);
      cs = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] part_addr;
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_cnt", {16'd0, frame_cnt}, 32'd0);

    // Write frame
    send_frame(8'd2, 32'd100, 32'd100, 0, 1'b0, 1'b0, 1'b0);
    chk("wr_valid", {31'd0, frame_valid}, 32'd1);
    chk("wr_cmd", {24'd0, frame_cmd}, 32'd2);
    chk("wr_addr", frame_addr, 32'd100);
    chk("wr_data", frame_data, 32'd100);
    chk("wr_cnt", {16'd0, frame_cnt}, 32'd1);

    // Read frame with 32 dummy ones
    do_reset();
    send_frame(8'd11, 32'd100, 32'h0, 32, 1'b0, 1'b0, 1'b0);
    chk("rd_cmd", {24'd0, frame_cmd}, 32'd11);
    chk("rd_data", frame_data, 32'd0);
    chk("rd_cnt", {16'd0, frame_cnt}, 32'd1);

    // Back-to-back with cs held low
    do_reset();
    ready = 1'b1;
    send_frame(8'd2, 32'h0000_0010, 32'hCAFE_0001, 0, 1'b0, 1'b1, 1'b0);
    send_frame(8'd11, 32'h0000_0020, 32'hCAFE_0002, 32, 1'b0, 1'b0, 1'b0);
    chk("b2b_cnt", {16'd0, frame_cnt}, 32'd2);
    chk("b2b_abort", {31'd0, abort_o}, 32'd0);
    chk("b2b_last_data", frame_data, 32'hCAFE_0002);

    // Backpressure
    do_reset();
    send_frame(8'd2, 32'd1, 32'd11, 0, 1'b0, 1'b0, 1'b0);
    send_frame(8'd5, 32'd2, 32'd22, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_cmd", {24'd0, frame_cmd}, 32'd2);
    chk("bp_ovf", {31'd0, overflow_o}, 32'd1);
    chk("bp_cnt", {16'd0, frame_cnt}, 32'd1);
    @(negedge clk);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_drop", {31'd0, frame_valid}, 32'd0);

    // Abort after 20 address bits, then a clean frame
    do_reset();
    part_addr = 32'hFFFF_0000;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 7; i >= 0; i--) tx_bit(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 12; i--) tx_bit(part_addr[i], 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cs = 1'b1;
    abort_flag = 1'b1;
    repeat (3) @(negedge clk);
    chk("ab_abort", {31'd0, abort_o}, 32'd1);
    chk("ab_novalid", {31'd0, frame_valid}, 32'd0);
    send_frame(8'd3, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0);
    chk("ab_next_addr", frame_addr, 32'hDEAD_BEEF);
    chk("ab_next_data", frame_data, 32'h1234_5678);

    // Reset mid-DATA
    do_reset();
    part_addr = 32'd7;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 7; i >= 0; i--) tx_bit(i == 1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 0; i--) tx_bit(part_addr[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tx_bit(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; cs = 1'b1; abort_flag = 1'b0; done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_abort", {31'd0, abort_o}, 32'd0);
    send_frame(8'd2, 32'd9, 32'd99, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_next_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("rst_next_data", frame_data, 32'd99);

    // cs rises on the final data rise: aborted, no record
    do_reset();
    send_frame(8'd2, 32'd5, 32'd6, 0, 1'b0, 1'b0, 1'b1);
    chk("cut_abort", {31'd0, abort_o}, 32'd1);
    chk("cut_novalid", {31'd0, frame_valid}, 32'd0);

    // Rise in the same cycle as the cs fall is cmd bit7
    do_reset();
    send_frame(8'hA5, 32'h0000_0001, 32'h0000_0002, 0, 1'b1, 1'b0, 1'b0);
    chk("same_edge_cmd", {24'd0, frame_cmd}, 32'h0000_00A5);
    chk("same_edge_data", frame_data, 32'd2);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
